// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } load_state_t;

  // An image is well-formed only if it ends on a whole 32-bit word.
  function automatic logic word_aligned(input logic [1:0] i_low_bits);
    return i_low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/imem_loader_byte_ram.sv
// Byte-wide instruction store: one synchronous write port and one
// combinational big-endian 32-bit read port that wraps modulo DEPTH.
module imem_byte_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [7:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_raddr1;
  logic [ADDR_W-1:0] w_raddr2;
  logic [ADDR_W-1:0] w_raddr3;

  // Contents survive reset on purpose; only the loader decides when they are valid.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr1 = i_raddr + ADDR_W'(1);
  assign w_raddr2 = i_raddr + ADDR_W'(2);
  assign w_raddr3 = i_raddr + ADDR_W'(3);

  assign o_rdata = {r_mem[i_raddr], r_mem[w_raddr1], r_mem[w_raddr2], r_mem[w_raddr3]};

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into the instruction store and holds the CPU
// until a complete, word-aligned image has been written.
//
//   state | meaning
//   IDLE  | no image yet / after reset; CPU held
//   LOAD  | accepting bytes, one per cycle when in_valid
//   DONE  | image complete and aligned; CPU released
//   ERR   | image misaligned or overflowed; CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       instr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH - 1);

  load_state_t r_state;
  load_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_xfer;
  logic              w_we;
  logic              w_enter_load;
  logic              w_store_full;
  logic              w_unused_pc;

  assign w_xfer       = in_valid && (r_state == ST_LOAD);
  assign w_count_inc  = r_count + (ADDR_W+1)'(1);
  assign w_store_full = (r_count == FULL_CNT);
  assign w_enter_load = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
  // Reset wins over a byte presented in the same cycle.
  assign w_we         = w_xfer && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          if (in_last) begin
            w_state_nxt = word_aligned(w_count_inc[1:0]) ? ST_DONE : ST_ERR;
          end else if (w_store_full) begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (r_state)
      ST_LOAD: in_ready = 1'b1;
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      ST_ERR:  load_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_enter_load) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_xfer) begin
      r_ptr   <= r_ptr + ADDR_W'(1);
      r_count <= w_count_inc;
    end
  end

  assign byte_count = r_count;

  // Upper PC bits alias onto the small store.
  assign w_unused_pc = ^fetch_pc[31:ADDR_W];

  imem_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (in_data),
    .i_raddr (fetch_pc[ADDR_W-1:0]),
    .o_rdata (instr)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a reference model predicts status and
// fetch data, expectations are queued and popped when the DUT is sampled.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [31:0]       fetch_pc = 32'h0;
  logic [31:0]       instr;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   byte_count;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .fetch_pc   (fetch_pc),
    .instr      (instr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         m_state = M_IDLE;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] prog [28];

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [31:0] m_instr(input logic [31:0] pc);
    int a;
    a = int'(pc % 32'(DEPTH));
    return {m_mem[a], m_mem[(a+1)%DEPTH], m_mem[(a+2)%DEPTH], m_mem[(a+3)%DEPTH]};
  endfunction

  task automatic push_status();
    push("cpu_hold",   {31'b0, m_state != M_DONE});
    push("load_done",  {31'b0, m_state == M_DONE});
    push("load_err",   {31'b0, m_state == M_ERR});
    push("in_ready",   {31'b0, m_state == M_LOAD});
    push("byte_count", 32'(m_cnt));
  endtask

  task automatic check_status();
    pop_cmp({31'b0, cpu_hold});
    pop_cmp({31'b0, load_done});
    pop_cmp({31'b0, load_err});
    pop_cmp({31'b0, in_ready});
    pop_cmp({{(31-ADDR_W){1'b0}}, byte_count});
  endtask

  task automatic chk_instr(input logic [31:0] pc, input logic [31:0] e);
    fetch_pc = pc;
    push("instr", e);
    #1;
    pop_cmp(instr);
  endtask

  task automatic do_start();
    start = 1'b1;
    if (m_state != M_LOAD) begin
      m_state = M_LOAD;
      m_ptr   = 0;
      m_cnt   = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    push_status();
    check_status();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (m_state == M_LOAD) begin
      m_mem[m_ptr] = d;
      m_ptr = (m_ptr + 1) % DEPTH;
      m_cnt++;
      if (last) m_state = (m_cnt % 4 == 0) ? M_DONE : M_ERR;
      else if (m_cnt == DEPTH) m_state = M_ERR;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap_cycle();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    @(posedge clk); #1;
    in_last  = 1'b0;
  endtask

  initial begin
    prog = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h10, 8'h20,
             8'h8C, 8'h02, 8'h00, 8'h04, 8'h00, 8'h41, 8'h18, 8'h22,
             8'hAC, 8'h03, 8'h00, 8'h08, 8'h10, 8'h00, 8'hFF, 8'hFF,
             8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    push_status();
    check_status();

    // 28-byte program, back-to-back
    do_start();
    for (int i = 0; i < 28; i++) send_byte(prog[i], i == 27);
    push_status();
    check_status();
    chk_instr(32'd0, 32'h8C010000);
    chk_instr(32'd4, 32'h00201020);

    // Same image with gaps, plus a start pulse mid-load that must be ignored
    do_start();
    for (int i = 0; i < 28; i++) begin
      start = (i == 5);
      send_byte(prog[i], i == 27);
      start = 1'b0;
      if (i == 11) begin
        push_status();
        check_status();
      end
      if (i != 27) gap_cycle();
    end
    push_status();
    check_status();
    chk_instr(32'd0, 32'h8C010000);
    chk_instr(32'd4, 32'h00201020);
    chk_instr(32'd24, m_instr(32'd24));

    // Misaligned 6-byte image, then a good 4-byte image
    do_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), i == 5);
    push_status();
    check_status();
    do_start();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    push_status();
    check_status();
    chk_instr(32'd0, 32'hDEADBEEF);

    // Overflow: 33 bytes with no last marker
    do_start();
    for (int i = 0; i < 33; i++) send_byte(8'(i), 1'b0);
    push_status();
    check_status();
    chk_instr(32'd0, 32'h00010203);

    // Reset in the middle of a load, with a byte presented during reset
    do_start();
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    reset    = 1'b0;
    m_state  = M_IDLE;
    m_ptr    = 0;
    m_cnt    = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_status();
    check_status();
    chk_instr(32'd8, m_instr(32'd8));
    chk_instr(32'd0, m_instr(32'd0));

    // Full 32-byte load ending exactly at the top of the store
    do_start();
    for (int i = 0; i < 32; i++) send_byte(8'(i), i == 31);
    push_status();
    check_status();
    chk_instr(32'd30, 32'h1E1F0001);
    chk_instr(32'h20, 32'h00010203);
    chk_instr(32'hFFFF_FFFD, m_instr(32'hFFFF_FFFD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream writer for the instruction memory. Accepts a program as a valid/ready byte stream, stores it big-endian into a writable byte-addressed instruction store, and holds the CPU off until the image is complete and well-formed. Its combinational fetch port feeds the IF stage of the pipelined MIPS core in place of a hard-coded ROM.

## Interface
- DEPTH, 32, instruction store size in bytes (power of two, ≥4)
- ADDR_W, 5, log2(DEPTH)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- start  in  1  begin a new load (sampled in IDLE, DONE, ERR only)
- in_valid  in  1  in_data/in_last valid this cycle
- in_data  in  8  program byte; first byte is the MSB of the word at address 0
- in_last  in  1  marks the final byte of the image
- in_ready  out  1  loader accepts a byte this cycle
- fetch_pc  in  32  byte address from IF stage
- instr  out  32  {M[pc], M[pc+1], M[pc+2], M[pc+3]}, addresses modulo DEPTH
- cpu_hold  out  1  stall request to the pipeline
- load_done  out  1  image loaded successfully
- load_err  out  1  image rejected
- byte_count  out  ADDR_W+1  bytes accepted in the current or last load

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE: cpu_hold=1, in_ready=0, done=err=0. start → LOAD.
- Entry to LOAD clears the write pointer and byte_count to 0.
- LOAD: in_ready=1. A transfer occurs when in_valid && in_ready. Each transfer writes in_data to M[ptr], increments ptr and byte_count.
- Transfer with in_last=1: new count a multiple of 4 → DONE; otherwise → ERR.
- Transfer with in_last=0 when byte_count==DEPTH-1 (store full, no last) → ERR (overflow). The byte is still written.
- start in LOAD is ignored.
- DONE: cpu_hold=0, load_done=1, in_ready=0. start → LOAD.
- ERR: cpu_hold=1, load_err=1, in_ready=0. start → LOAD.
- in_valid outside LOAD: ignored, no write.
- Fetch port: purely combinational, always active; data undefined-by-contract while cpu_hold=1. Address bits above ADDR_W ignored; pc+k wraps modulo DEPTH.
- Reset: state IDLE, ptr=0, byte_count=0, outputs cpu_hold=1, in_ready=0, load_done=0, load_err=0. Memory contents are not cleared. Reset mid-load abandons the load; no further writes.

## Timing
- Write latency 1 cycle: byte accepted at edge N readable on instr after edge N.
- in_ready is a decode of state only (no combinational path from in_valid).
- load_done/load_err and cpu_hold deassert/assert in the cycle after the edge that accepts the final byte.
- start → LOAD: in_ready=1 one cycle after start is sampled.
- Back-to-back transfers at one byte per cycle sustained; in_valid gaps allowed indefinitely.
- Reset has priority over all other events in the same cycle.

## Structure
- Shared package: state enum (IDLE/LOAD/DONE/ERR), default DEPTH/ADDR_W constants.
- Sub-module imem_byte_ram: DEPTH×8 array, one synchronous byte write port (we, waddr, wdata), one combinational 4-byte big-endian read port with modulo wrap. Loader holds FSM, pointer, counter, status.

## Test plan
- Load 28-byte program starting 8C 01 00 00 / 00 20 10 20, in_last on byte 28 → load_done=1, cpu_hold=0, byte_count=28, instr=0x8C010000 at pc 0, 0x00201020 at pc 4.
- Same image with in_valid toggled every other cycle → identical result; no writes during in_valid=0 cycles.
- 6-byte image with in_last on byte 6 → load_err=1, cpu_hold=1, byte_count=6; start then valid 4-byte load → load_done=1.
- 33 bytes without in_last → load_err on byte 32, in_ready=0 afterwards, byte_count=32.
- Reset asserted after 10 bytes → IDLE, in_ready=0, byte_count=0, cpu_hold=1; bytes presented afterwards not written.
- After full 32-byte load of 0x00..0x1F, fetch_pc=30 → instr=0x1E1F0001; fetch_pc=0x20 → instr=0x00010203.
